regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/multicycle producers and the register-file write port.
// The master modport drives the producers; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     pipe_we;
    logic [ADDRESS_WIDTH-1:0] pipe_rd;
    logic [DATA_WIDTH-1:0]    pipe_wd;
    logic                     mc_valid;
    logic                     mc_ready;
    logic [ADDRESS_WIDTH-1:0] mc_rd;
    logic [DATA_WIDTH-1:0]    mc_wd;
    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0]    WD3;
    logic                     stall_req;
    logic [1:0]               fifo_count;

    modport master (
        output pipe_we, pipe_rd, pipe_wd, mc_valid, mc_rd, mc_wd,
        input  mc_ready, WE3, A3, WD3, stall_req, fifo_count
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd, mc_valid, mc_rd, mc_wd,
        output mc_ready, WE3, A3, WD3, stall_req, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, multicycle results wait in a 2-entry FIFO.
// Define WBARB_STARVE_EN to add the starvation counter that also raises stall_req.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input logic                 CLK,
    input logic                 RST,
    regfile_wb_arbiter_if.slave wb
);
    logic [ADDRESS_WIDTH-1:0] rd_mem [2];
    logic [DATA_WIDTH-1:0]    wd_mem [2];
    logic                     head;
    logic [1:0]               count;
    logic                     stall;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     tail;
    logic                     pipe_active;
    logic                     push;
    logic                     pop;
    logic                     starve_hit;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    assign fifo_full   = (count == 2'd2);
    assign fifo_empty  = (count == 2'd0);
    assign tail        = head ^ count[0];
    assign pipe_active = wb.pipe_we && (wb.pipe_rd != '0);
    // Writes to register 0 are consumed but never queued.
    assign push        = wb.mc_valid && !fifo_full && (wb.mc_rd != '0);
    assign pop         = !pipe_active && !fifo_empty;

    assign wb.mc_ready   = !fifo_full;
    assign wb.fifo_count = count;
    assign wb.stall_req  = stall;

    always_comb begin
        wb.WE3 = 1'b0;
        wb.A3  = '0;
        wb.WD3 = '0;
        if (pipe_active) begin
            wb.A3  = wb.pipe_rd;
            wb.WD3 = wb.pipe_wd;
        end else if (!fifo_empty) begin
            wb.A3  = rd_mem[head];
            wb.WD3 = wd_mem[head];
        end
        wb.WE3 = !RST && (pipe_active || !fifo_empty);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[tail] <= wb.mc_rd;
            wd_mem[tail] <= wb.mc_wd;
        end
    end

`ifdef WBARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // Compare the updated value so the stall shows up the cycle after the limit is reached.
    assign starve_hit = (starve_next == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall <= 1'b0;
        end else begin
            stall <= fifo_full || starve_hit;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares every write-port cycle.
module tb_regfile_wb_arbiter;
    logic CLK;
    logic RST;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    regfile_wb_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .wb(bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.WE3 === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: cycle %0d got A3=%0d WD3=%h, required no write",
                         cyc, bus.A3, bus.WD3);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.a !== bus.A3 || mon_e.d !== bus.WD3) begin
                    n_bad++;
                    $display("FAIL wr_data: cycle %0d got A3=%0d WD3=%h, required cycle %0d A3=%0d WD3=%h",
                             cyc, bus.A3, bus.WD3, mon_e.cyc, mon_e.a, mon_e.d);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            n_vec++;
            n_bad++;
            mon_e = exp_q.pop_front();
            $display("FAIL wr_missing: cycle %0d got WE3=%b, required A3=%0d WD3=%h at cycle %0d",
                     cyc, bus.WE3, mon_e.a, mon_e.d, mon_e.cyc);
        end
    end

    task automatic sb_push(input int c, input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.cyc = c;
        w.a   = a;
        w.d   = d;
        exp_q.push_back(w);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        bus.pipe_we = we;
        bus.pipe_rd = rd;
        bus.pipe_wd = wd;
    endtask

    task automatic mc(input logic v, input logic [4:0] rd, input logic [31:0] wd);
        bus.mc_valid = v;
        bus.mc_rd    = rd;
        bus.mc_wd    = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1;
        pipe(1'b0, 5'd0, 32'h0);
        mc(1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge CLK);
        #3;
        chk("we3_in_reset", {31'b0, bus.WE3}, 32'd0);
        RST = 1'b0;
        step();
        #2;
        chk("rst_fifo_count", {30'b0, bus.fifo_count}, 32'd0);
        chk("rst_mc_ready", {31'b0, bus.mc_ready}, 32'd1);
        chk("rst_stall_req", {31'b0, bus.stall_req}, 32'd0);

        // Pipeline write, zero latency
        step();
        pipe(1'b1, 5'd5, 32'hDEADBEEF);
        sb_push(cyc, 5'd5, 32'hDEADBEEF);
        step();
        pipe(1'b0, 5'd0, 32'h0);

        // Single multicycle push, drains the next cycle
        mc(1'b1, 5'd7, 32'h11);
        sb_push(cyc + 1, 5'd7, 32'h11);
        #2;
        chk("mc_ready_idle", {31'b0, bus.mc_ready}, 32'd1);
        chk("count_before_push", {30'b0, bus.fifo_count}, 32'd0);
        step();
        mc(1'b0, 5'd0, 32'h0);
        #2;
        chk("count_after_push", {30'b0, bus.fifo_count}, 32'd1);
        step();
        #2;
        chk("count_after_drain", {30'b0, bus.fifo_count}, 32'd0);

        // Fill FIFO behind a busy pipeline, then drain in order
        pipe(1'b1, 5'd1, 32'hA0);
        sb_push(cyc, 5'd1, 32'hA0);
        mc(1'b1, 5'd2, 32'hB0);
        step();
        pipe(1'b1, 5'd3, 32'hA1);
        sb_push(cyc, 5'd3, 32'hA1);
        mc(1'b1, 5'd4, 32'hB1);
        #2;
        chk("fill_count1", {30'b0, bus.fifo_count}, 32'd1);
        chk("fill_ready1", {31'b0, bus.mc_ready}, 32'd1);
        step();
        pipe(1'b1, 5'd6, 32'hA2);
        sb_push(cyc, 5'd6, 32'hA2);
        mc(1'b1, 5'd9, 32'hBAD);
        #2;
        chk("full_count", {30'b0, bus.fifo_count}, 32'd2);
        chk("full_ready", {31'b0, bus.mc_ready}, 32'd0);
        chk("full_stall_early", {31'b0, bus.stall_req}, 32'd0);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        mc(1'b0, 5'd0, 32'h0);
        sb_push(cyc, 5'd2, 32'hB0);
        sb_push(cyc + 1, 5'd4, 32'hB1);
        #2;
        chk("full_stall", {31'b0, bus.stall_req}, 32'd1);
        step();
        #2;
        chk("drain_count1", {30'b0, bus.fifo_count}, 32'd1);
        chk("drain_stall_held", {31'b0, bus.stall_req}, 32'd1);
        step();
        #2;
        chk("drain_count0", {30'b0, bus.fifo_count}, 32'd0);
        chk("drain_stall_clear", {31'b0, bus.stall_req}, 32'd0);

        // Register 0 on either source is ignored
        mc(1'b1, 5'd0, 32'h55);
        #2;
        chk("rd0_ready", {31'b0, bus.mc_ready}, 32'd1);
        step();
        mc(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd0, 32'h77);
        #2;
        chk("rd0_count", {30'b0, bus.fifo_count}, 32'd0);
        chk("pipe_rd0_we3", {31'b0, bus.WE3}, 32'd0);
        step();
        pipe(1'b0, 5'd0, 32'h0);

        // Starvation: one queued entry held off for four cycles
        pipe(1'b1, 5'd8, 32'hC0);
        sb_push(cyc, 5'd8, 32'hC0);
        mc(1'b1, 5'd10, 32'hD0);
        for (int i = 1; i <= 4; i++) begin
            step();
            mc(1'b0, 5'd0, 32'h0);
            pipe(1'b1, 5'(8 + i), 32'hC0 + i);
            sb_push(cyc, 5'(8 + i), 32'hC0 + i);
            #2;
            chk("starve_quiet", {31'b0, bus.stall_req}, 32'd0);
        end
        step();
        pipe(1'b1, 5'd13, 32'hC5);
        sb_push(cyc, 5'd13, 32'hC5);
        #2;
        chk("starve_count", {30'b0, bus.fifo_count}, 32'd1);
`ifdef WBARB_STARVE_EN
        chk("starve_stall", {31'b0, bus.stall_req}, 32'd1);
`else
        chk("starve_stall", {31'b0, bus.stall_req}, 32'd0);
`endif
        step();
        pipe(1'b0, 5'd0, 32'h0);
        sb_push(cyc, 5'd10, 32'hD0);
        #2;
`ifdef WBARB_STARVE_EN
        chk("starve_stall_held", {31'b0, bus.stall_req}, 32'd1);
`else
        chk("starve_stall_held", {31'b0, bus.stall_req}, 32'd0);
`endif
        step();
        #2;
        chk("starve_release", {31'b0, bus.stall_req}, 32'd0);
        chk("starve_drained", {30'b0, bus.fifo_count}, 32'd0);

        // Reset with a full FIFO
        pipe(1'b1, 5'd12, 32'hE0);
        sb_push(cyc, 5'd12, 32'hE0);
        mc(1'b1, 5'd13, 32'hF0);
        step();
        pipe(1'b1, 5'd14, 32'hE1);
        sb_push(cyc, 5'd14, 32'hE1);
        mc(1'b1, 5'd15, 32'hF1);
        step();
        pipe(1'b1, 5'd16, 32'hE2);
        sb_push(cyc, 5'd16, 32'hE2);
        mc(1'b0, 5'd0, 32'h0);
        #2;
        chk("rst_full_count", {30'b0, bus.fifo_count}, 32'd2);
        step();
        pipe(1'b0, 5'd0, 32'h0);
        mc(1'b1, 5'd17, 32'h17);
        RST = 1'b1;
        #2;
        chk("we3_during_rst", {31'b0, bus.WE3}, 32'd0);
        chk("stall_before_rst", {31'b0, bus.stall_req}, 32'd1);
        step();
        RST = 1'b0;
        mc(1'b0, 5'd0, 32'h0);
        #2;
        chk("post_rst_count", {30'b0, bus.fifo_count}, 32'd0);
        chk("post_rst_ready", {31'b0, bus.mc_ready}, 32'd1);
        chk("post_rst_stall", {31'b0, bus.stall_req}, 32'd0);

        // Transfer offered during reset is dropped
        step();
        RST = 1'b1;
        mc(1'b1, 5'd18, 32'h99);
        step();
        RST = 1'b0;
        mc(1'b0, 5'd0, 32'h0);
        #2;
        chk("drop_inflight", {30'b0, bus.fifo_count}, 32'd0);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
